// File: rtl/uart_rx.sv
// uart_rx: UART receiver for the team's serial link.
//
// Samples an asynchronous serial line at mid-bit and rebuilds LSB-first frames.
// Each frame is one low start bit, PAYLOAD_BITS data bits, then STOP_BITS high
// stop bits. Each received payload is presented with a one-cycle strobe.
// Framing errors and line breaks are reported as one-cycle pulses.
//
// Parameters:
//   CLK_HZ        system clock frequency in Hz
//   BIT_RATE      line bit rate in bits/s
//   PAYLOAD_BITS  data bits per frame (1..16)
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports:
//   clk                input   system clock, rising edge
//   reset              input   synchronous active-high reset
//   uart_rxd           input   asynchronous serial line, idles high
//   uart_rx_en         input   high allows new frames to start
//   uart_rx_data       output  last received payload, bit 0 = first data bit
//   uart_rx_valid      output  one-cycle pulse, uart_rx_data holds a good frame
//   uart_rx_frame_err  output  one-cycle pulse, a stop bit was sampled low
//   uart_rx_break      output  one-cycle pulse, framing error with zero payload

module uart_rx #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int BIT_RATE     = 9600,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int BAUD_TICKS = CLK_HZ / BIT_RATE;
    localparam int HALF_TICKS = BAUD_TICKS / 2;
    localparam int BAUD_W     = (BAUD_TICKS > 2) ? $clog2(BAUD_TICKS) : 1;
    localparam int BIT_MAX    = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int BIT_W      = $clog2(BIT_MAX + 1);

    localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(BAUD_TICKS - 1);
    localparam logic [BAUD_W-1:0] HALF_RELOAD = BAUD_W'(HALF_TICKS - 1);
    localparam logic [BIT_W-1:0]  LAST_DATA   = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [BIT_W-1:0]  LAST_STOP   = BIT_W'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        RECV,
        STOP
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    rxd_meta;
    logic                    rxd_s;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [PAYLOAD_BITS-1:0] shift_reg;
    logic [PAYLOAD_BITS-1:0] shift_next;
    logic                    armed;
    logic                    err_flag;
    logic                    baud_tick;
    logic                    frame_bad;

    // Two-flop synchroniser; only rxd_s is ever looked at downstream.
    always_ff @(posedge clk) begin
        if (reset) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= uart_rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Next-state logic plus the mid-bit sample helpers shared with the datapath.
    // The shift register fills from the MSB so the first data bit ends in bit 0.
    always_comb begin
        state_next = state;
        baud_tick  = (baud_cnt == '0);
        frame_bad  = err_flag | ~rxd_s;
        shift_next = shift_reg >> 1;
        shift_next[PAYLOAD_BITS-1] = rxd_s;
        case (state)
            IDLE: begin
                if (!rxd_s && armed && uart_rx_en) begin
                    state_next = START;
                end
            end
            START: begin
                if (baud_tick) begin
                    state_next = rxd_s ? IDLE : RECV;
                end
            end
            RECV: begin
                if (baud_tick && (bit_cnt == LAST_DATA)) begin
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at the middle of the last stop bit leaves half a bit
                // of margin to catch a back-to-back start bit.
                if (baud_tick && (bit_cnt == LAST_STOP)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and datapath: baud/bit counters, shift register,
    // sticky stop-bit error and the registered output strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            baud_cnt          <= '0;
            bit_cnt           <= '0;
            shift_reg         <= '0;
            armed             <= 1'b1;
            err_flag          <= 1'b0;
            uart_rx_data      <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
        end else begin
            state             <= state_next;
            uart_rx_valid     <= 1'b0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
            case (state)
                IDLE: begin
                    // A framing error disarms the receiver so a line held low
                    // cannot retrigger until it has been seen high again.
                    if (rxd_s) begin
                        armed <= 1'b1;
                    end
                    if (state_next == START) begin
                        baud_cnt <= HALF_RELOAD;
                        bit_cnt  <= '0;
                        err_flag <= 1'b0;
                    end
                end
                START: begin
                    if (baud_tick) begin
                        if (!rxd_s) begin
                            baud_cnt <= BAUD_RELOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                RECV: begin
                    if (baud_tick) begin
                        shift_reg <= shift_next;
                        baud_cnt  <= BAUD_RELOAD;
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_tick) begin
                        if (!rxd_s) begin
                            err_flag <= 1'b1;
                        end
                        if (bit_cnt == LAST_STOP) begin
                            uart_rx_data <= shift_reg;
                            if (frame_bad) begin
                                uart_rx_frame_err <= 1'b1;
                                uart_rx_break     <= (shift_reg == '0);
                                armed             <= 1'b0;
                            end else begin
                                uart_rx_valid <= 1'b1;
                            end
                        end else begin
                            bit_cnt  <= bit_cnt + BIT_W'(1);
                            baud_cnt <= BAUD_RELOAD;
                        end
                    end else begin
                        baud_cnt <= baud_cnt - BAUD_W'(1);
                    end
                end
                default: begin
                    baud_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver: the receive end of the serial link driven by the team's UART transmitter. It samples an asynchronous serial line at mid-bit and reassembles LSB-first frames: 1 start bit (low), PAYLOAD_BITS data bits, STOP_BITS stop bits (high). It presents each received byte with a one-cycle valid strobe, and flags framing errors and line breaks to the host logic.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
BIT_RATE, 9600, line bit rate in bits/s; BAUD_TICKS = CLK_HZ / BIT_RATE (integer divide), HALF_TICKS = BAUD_TICKS / 2
PAYLOAD_BITS, 8, data bits per frame (1..16)
STOP_BITS, 1, stop bits per frame (1 or 2)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
uart_rxd  input  1  asynchronous serial line; idles high
uart_rx_en  input  1  high = new frames may start; low = ignore new start bits
uart_rx_data  output  PAYLOAD_BITS  last received payload; bit 0 = first data bit on the line
uart_rx_valid  output  1  one-cycle pulse: uart_rx_data holds a good frame
uart_rx_frame_err  output  1  one-cycle pulse: a stop bit was sampled low
uart_rx_break  output  1  one-cycle pulse: frame error with all-zero payload (line break)

Behaviour:
- Reset: uart_rx_data=0, uart_rx_valid=0, uart_rx_frame_err=0, uart_rx_break=0. State=IDLE, counters=0, armed=1, synchroniser flops=1. A reset mid-frame aborts the frame, and no strobe is produced.
- Input synchroniser: 2 flops on uart_rxd produce rxd_s, which gives 2 cycles of latency. Only rxd_s is used internally.
- A single baud_cnt down-counter is sized to hold BAUD_TICKS-1. A bit_cnt counter is sized to hold max(PAYLOAD_BITS, STOP_BITS).
- IDLE:
  - If rxd_s==1, set armed=1.
  - On the first cycle D with rxd_s==0, armed==1 and uart_rx_en==1: load baud_cnt=HALF_TICKS-1 and bit_cnt=0, then go to START.
  - If uart_rx_en goes low mid-frame, the frame still completes.
- START: decrement baud_cnt. At 0, sample rxd_s (cycle D+HALF_TICKS).
  - rxd_s==0: load baud_cnt=BAUD_TICKS-1 and go to RECV.
  - rxd_s==1 (glitch / false start): go to IDLE, no strobe.
- RECV: decrement baud_cnt. At 0, shift rxd_s into the MSB of the shift register (shift right) and increment bit_cnt.
  - After the PAYLOAD_BITS-th sample: clear bit_cnt and go to STOP.
  - Otherwise reload BAUD_TICKS-1.
  - Data sample k (0-based) is taken at cycle D+HALF_TICKS+(k+1)*BAUD_TICKS.
- STOP: same mid-bit sampling, STOP_BITS samples. Any stop sample ==0 sets a sticky err flag for this frame. On the last stop sample, go to IDLE with the following actions registered:
  - uart_rx_data <= shift register, in every case, error or not.
  - No error: uart_rx_valid=1 for exactly one cycle, at cycle D+HALF_TICKS+(PAYLOAD_BITS+STOP_BITS)*BAUD_TICKS+1.
  - Error: uart_rx_frame_err=1 for one cycle at that same cycle, uart_rx_valid stays 0, and armed is cleared. Clearing armed means a held-low line cannot re-trigger until rxd_s returns high.
  - Error with payload == 0: uart_rx_break=1 in the same cycle as uart_rx_frame_err.
- Return to IDLE happens at the mid-point of the last stop bit, which gives half a bit of resync margin for a back-to-back start bit.
- uart_rx_valid, uart_rx_frame_err and uart_rx_break are never high for more than one cycle. uart_rx_valid and uart_rx_frame_err are never high together.
- uart_rx_data holds its value until the next frame completion or reset.

Test Plan:
1. Bench params CLK_HZ=1000, BIT_RATE=100 (BAUD_TICKS=10, HALF=5). Drive frame 0xA5 with 1 stop bit -> uart_rx_data=0xA5, uart_rx_valid pulses once at D+5+90+1 = D+96, frame_err=0, break=0.
2. Back-to-back frames 0x00 then 0xFF, second start bit immediately after the stop bit -> two valid pulses, data 0x00 then 0xFF, nothing dropped.
3. Frame 0x3C with the stop bit driven low -> frame_err pulse, valid=0, break=0, uart_rx_data=0x3C. A following good frame 0x12 -> valid, data=0x12.
4. Line held low for 30 bit times, then high -> exactly one frame_err+break pulse and no further strobes while low. The next frame 0x55 is received correctly.
5. Low glitch of 3 cycles on an idle line -> START samples high and returns to IDLE, no strobes. uart_rx_en=0 during a full frame -> no strobes.
6. Assert reset midway through data bit 4 of frame 0x99 -> all outputs 0 the next cycle and no strobe for the aborted frame. A subsequent frame 0x66 is received correctly. Repeat test 1 with STOP_BITS=2: valid at D+5+100+1.
